// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and its neighbours.
package hazard_ctrl_pkg;

    // Wait-state sequencer encoding; the values are visible on state_o.
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StAbort   = 2'd2
    } hz_state_e;

    // Write-back select value that marks a load in EX.
    localparam logic [1:0] WDSEL_LOAD = 2'b01;

    // Next-PC operation encodings shared with the branch logic.
    typedef enum logic [1:0] {
        NpcPlus4  = 2'd0,
        NpcBranch = 2'd1,
        NpcJump   = 2'd2,
        NpcJalr   = 2'd3
    } npc_op_e;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use hazard detector. It is shared with the forwarding unit.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_RegWrite_i,
    input  logic [1:0] ex_WDsel_i,
    output logic       lu_o
);

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired, so a load targeting it can never create a dependency.
    always_comb begin
        ex_is_load = ex_RegWrite_i & (ex_WDsel_i == WDSEL_LOAD) & (ex_rd_i != 5'd0);
        rs1_hit    = id_use_rs1_i & (id_rs1_i == ex_rd_i);
        rs2_hit    = id_use_rs2_i & (id_rs2_i == ex_rd_i);
        lu_o       = ex_is_load & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and data-memory
// wait states with a timeout abort.
// Build option: define HAZARD_PERF_CNT_EN to add the three performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_RegWrite_i,
    input  logic [1:0]  ex_WDsel_i,
    input  logic        ex_br_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        pc_pause_o,
    output logic        if_id_pause_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        id_ex_hold_o,
    output logic        ex_mem_hold_o,
    output logic        mem_wb_flush_o,
    output logic        mem_err_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_lu_cnt_o,
    output logic [31:0] perf_br_cnt_o,
    output logic [31:0] perf_mem_cnt_o,
`endif
    output logic [1:0]  state_o
);

    localparam logic [CNT_W-1:0] CntTimeout = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;
    logic             ms;
    logic             mem_done;
    logic             lu_bubble;
    logic             br_flush;

    hazard_detect u_detect (
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_use_rs1_i  (id_use_rs1_i),
        .id_use_rs2_i  (id_use_rs2_i),
        .ex_rd_i       (ex_rd_i),
        .ex_RegWrite_i (ex_RegWrite_i),
        .ex_WDsel_i    (ex_WDsel_i),
        .lu_o          (lu)
    );

    assign ms       = mem_req_i & ~mem_ready_i;
    // A dropped request while waiting counts as completion.
    assign mem_done = mem_ready_i | ~mem_req_i;
    assign state_o  = state_q;

    // Next-state, wait counter and control outputs; everything is forced low in reset.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_pause_o     = 1'b0;
        if_id_pause_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        id_ex_hold_o   = 1'b0;
        ex_mem_hold_o  = 1'b0;
        mem_wb_flush_o = 1'b0;
        mem_err_o      = 1'b0;
        lu_bubble      = 1'b0;
        br_flush       = 1'b0;

        unique case (state_q)
            StRun, StMemWait: begin
                if ((state_q == StRun) ? ms : ~mem_done) begin
                    // Freeze the front of the pipe and bubble WB until memory answers.
                    pc_pause_o     = 1'b1;
                    if_id_pause_o  = 1'b1;
                    id_ex_hold_o   = 1'b1;
                    ex_mem_hold_o  = 1'b1;
                    mem_wb_flush_o = 1'b1;
                    if (state_q == StRun) begin
                        state_d = StMemWait;
                        cnt_d   = CNT_W'(1);
                    end else if (cnt_q == CntTimeout) begin
                        state_d = StAbort;
                    end else if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = StRun;
                    cnt_d   = '0;
                    if (ex_br_taken_i) begin
                        // PC stays live so it loads the branch target; lu is moot.
                        br_flush      = 1'b1;
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (lu) begin
                        lu_bubble     = 1'b1;
                        pc_pause_o    = 1'b1;
                        if_id_pause_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end
                end
            end
            StAbort: begin
                // Drop the faulting access and let the pipeline drain.
                mem_err_o      = 1'b1;
                mem_wb_flush_o = 1'b1;
                state_d        = StRun;
                cnt_d          = '0;
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase

        if (rst) begin
            pc_pause_o     = 1'b0;
            if_id_pause_o  = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_flush_o  = 1'b0;
            id_ex_hold_o   = 1'b0;
            ex_mem_hold_o  = 1'b0;
            mem_wb_flush_o = 1'b0;
            mem_err_o      = 1'b0;
            lu_bubble      = 1'b0;
            br_flush       = 1'b0;
        end
    end

    // Sequencer state and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_q, perf_br_q, perf_mem_q;

    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_q  <= '0;
            perf_br_q  <= '0;
            perf_mem_q <= '0;
        end else begin
            perf_lu_q  <= perf_lu_q + {31'd0, lu_bubble};
            perf_br_q  <= perf_br_q + {31'd0, br_flush};
            perf_mem_q <= perf_mem_q + {31'd0, state_q == StMemWait};
        end
    end

    assign perf_lu_cnt_o  = perf_lu_q;
    assign perf_br_cnt_o  = perf_br_q;
    assign perf_mem_cnt_o = perf_mem_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl, built with MEM_TIMEOUT=4.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] wds;
        logic       br;
        logic       req;
        logic       rdy;
    } in_t;

    // ctrl bits: pc_pause, if_id_pause, if_id_flush, id_ex_flush,
    //            id_ex_hold, ex_mem_hold, mem_wb_flush, mem_err
    typedef struct packed {
        logic [7:0] ctrl;
        logic [1:0] st;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t ex;
    } vec_t;

    localparam logic [7:0] NONE   = 8'b0000_0000;
    localparam logic [7:0] STALL  = 8'b1101_0000;
    localparam logic [7:0] FLUSH  = 8'b0011_0000;
    localparam logic [7:0] FREEZE = 8'b1100_1110;
    localparam logic [7:0] ABRT   = 8'b0000_0011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    in_t         cur = '0;
    logic        pc_pause, if_id_pause, if_id_flush, id_ex_flush;
    logic        id_ex_hold, ex_mem_hold, mem_wb_flush, mem_err;
    logic [1:0]  state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu, perf_br, perf_mem;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1_i       (cur.rs1),
        .id_rs2_i       (cur.rs2),
        .id_use_rs1_i   (cur.u1),
        .id_use_rs2_i   (cur.u2),
        .ex_rd_i        (cur.rd),
        .ex_RegWrite_i  (cur.rw),
        .ex_WDsel_i     (cur.wds),
        .ex_br_taken_i  (cur.br),
        .mem_req_i      (cur.req),
        .mem_ready_i    (cur.rdy),
        .pc_pause_o     (pc_pause),
        .if_id_pause_o  (if_id_pause),
        .if_id_flush_o  (if_id_flush),
        .id_ex_flush_o  (id_ex_flush),
        .id_ex_hold_o   (id_ex_hold),
        .ex_mem_hold_o  (ex_mem_hold),
        .mem_wb_flush_o (mem_wb_flush),
        .mem_err_o      (mem_err),
`ifdef HAZARD_PERF_CNT_EN
        .perf_lu_cnt_o  (perf_lu),
        .perf_br_cnt_o  (perf_br),
        .perf_mem_cnt_o (perf_mem),
`endif
        .state_o        (state)
    );

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic [4:0] rd, input logic rw,
                               input logic [1:0] wds, input logic br, input logic req,
                               input logic rdy);
        in_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.rw = rw; v.wds = wds; v.br = br; v.req = req; v.rdy = rdy;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
    task automatic step(input in_t in, input logic [7:0] ctrl, input logic [1:0] st,
                        input string nm);
        exp_t e;
        logic [7:0] act;
        cur = in;
        e.ctrl = ctrl;
        e.st = st;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        act = {pc_pause, if_id_pause, if_id_flush, id_ex_flush,
               id_ex_hold, ex_mem_hold, mem_wb_flush, mem_err};
        n_checks++;
        if (act !== e.ctrl) begin
            n_fail++;
            $display("FAIL %s ctrl: got %b expected %b", nm, act, e.ctrl);
        end
        n_checks++;
        if (state !== e.st) begin
            n_fail++;
            $display("FAIL %s state: got %0d expected %0d", nm, state, e.st);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_t idle, ms_in;
        idle  = '0;
        ms_in = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Single-cycle RUN-state vectors.
        vecs[0]  = '{in: mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex: '{NONE,  2'd0}};
        vecs[1]  = '{in: mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 0), ex: '{STALL, 2'd0}};
        vecs[2]  = '{in: mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0), ex: '{NONE,  2'd0}};
        vecs[3]  = '{in: mk(5, 0, 0, 0, 5, 1, 1, 0, 0, 0), ex: '{NONE,  2'd0}};
        vecs[4]  = '{in: mk(3, 7, 1, 1, 7, 1, 1, 0, 0, 0), ex: '{STALL, 2'd0}};
        vecs[5]  = '{in: mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0), ex: '{NONE,  2'd0}};
        vecs[6]  = '{in: mk(5, 0, 1, 0, 5, 0, 1, 0, 0, 0), ex: '{NONE,  2'd0}};
        vecs[7]  = '{in: mk(5, 0, 1, 0, 5, 1, 1, 1, 0, 0), ex: '{FLUSH, 2'd0}};
        vecs[8]  = '{in: mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ex: '{FLUSH, 2'd0}};
        vecs[9]  = '{in: mk(5, 0, 1, 0, 5, 1, 2, 0, 0, 0), ex: '{NONE,  2'd0}};
        vecs[10] = '{in: mk(9, 9, 1, 1, 9, 1, 1, 0, 1, 1), ex: '{STALL, 2'd0}};
        vecs[11] = '{in: mk(5, 5, 0, 1, 5, 1, 1, 0, 0, 0), ex: '{STALL, 2'd0}};

        // Outputs stay low while reset is held, even with a stall request present.
        cur = ms_in;
        @(posedge clk);
        #1;
        step(ms_in, NONE, 2'd0, "reset_hold");
        rst = 1'b0;
        step(idle, NONE, 2'd0, "reset_release");

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].in, vecs[i].ex.ctrl, vecs[i].ex.st, $sformatf("vec%0d", i));
        end

        // Load-use bubble lasts one cycle; the load then moves on.
        step(mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 0), STALL, 2'd0, "lu_bubble");
        step(mk(5, 0, 1, 0, 6, 1, 0, 0, 0, 0), NONE,  2'd0, "lu_cleared");

        // Three frozen cycles, branch/lu ignored while frozen, then ready.
        step(ms_in, FREEZE, 2'd0, "mw_enter");
        step(mk(5, 0, 1, 0, 5, 1, 1, 1, 1, 0), FREEZE, 2'd1, "mw_ignore_br_lu");
        step(ms_in, FREEZE, 2'd1, "mw_wait2");
        step(mk(5, 0, 1, 0, 5, 1, 1, 0, 1, 1), STALL, 2'd1, "mw_ready_lu");
        step(idle, NONE, 2'd0, "mw_back_run");

        // Timeout: entry, four waiting cycles, one abort cycle, then RUN.
        step(ms_in, FREEZE, 2'd0, "to_enter");
        for (int i = 1; i <= 4; i++) begin
            step(ms_in, FREEZE, 2'd1, $sformatf("to_wait%0d", i));
        end
        step(ms_in, ABRT, 2'd2, "to_abort");
        step(idle, NONE, 2'd0, "to_run");
        step(idle, NONE, 2'd0, "to_err_once");

        // Dropping mem_req while waiting acts as completion.
        step(ms_in, FREEZE, 2'd0, "drop_enter");
        step(idle, NONE, 2'd1, "drop_req");
        step(idle, NONE, 2'd0, "drop_run");

        // Synchronous reset in the middle of a wait.
        step(ms_in, FREEZE, 2'd0, "rst_enter");
        step(ms_in, FREEZE, 2'd1, "rst_waiting");
        rst = 1'b1;
        step(ms_in, NONE, 2'd1, "rst_mid_wait");
        rst = 1'b0;
        step(idle, NONE, 2'd0, "rst_after");
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if ({perf_lu, perf_br, perf_mem} !== 96'd0) begin
            n_fail++;
            $display("FAIL perf_after_rst: got %0d/%0d/%0d expected 0/0/0",
                     perf_lu, perf_br, perf_mem);
        end
`endif
        // Counter restarts cleanly after the reset.
        step(ms_in, FREEZE, 2'd0, "rst_reenter");
        step(idle, NONE, 2'd1, "rst_reexit");
        step(idle, NONE, 2'd0, "rst_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline-control block. It produces the pause/flush/hold controls that the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC consume.
- Detects load-use hazards, taken branches/jumps resolved in EX, and data-memory wait states.
- Sequences the wait states with a small FSM that includes a timeout.
- Sits beside the pipeline registers; its outputs feed their pause/flush inputs.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before abort.
- CNT_W, 5, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_rs1  in  5  rs1 index of the instruction in ID
- id_rs2  in  5  rs2 index of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_RegWrite  in  1  EX instruction writes the register file
- ex_WDsel  in  2  EX write-back select; 2'b01 = load
- ex_br_taken  in  1  EX resolved a taken branch or jump (NPCOp != sequential and condition true)
- mem_req  in  1  MEM stage is issuing a data-memory access
- mem_ready  in  1  data memory is completing the access this cycle
- pc_pause  out  1  hold the PC
- if_id_pause  out  1  hold IF/ID
- if_id_flush  out  1  clear IF/ID
- id_ex_flush  out  1  clear ID/EX (inserts a bubble)
- id_ex_hold  out  1  hold ID/EX contents (no clear)
- ex_mem_hold  out  1  hold EX/MEM
- mem_wb_flush  out  1  clear MEM/WB (bubble into WB)
- mem_err  out  1  one-cycle pulse on memory timeout
- state_o  out  2  current FSM state, for debug

Behaviour:
- FSM states are RUN=0, MEM_WAIT=1, ABORT=2. State is registered.
- Control outputs are combinational from state and inputs; they take effect at the same clock edge the pipeline registers sample.
- Reset: state=RUN, wait counter=0, mem_err=0.
- While rst=1, all control outputs are forced to 0. The pipeline registers clear themselves on rst.
- Load-use hazard, lu:
  - lu = ex_RegWrite & (ex_WDsel==2'b01) & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Memory stall, ms:
  - ms = mem_req & ~mem_ready.
- RUN, priority ms > ex_br_taken > lu:
  - ms: pc_pause, if_id_pause, id_ex_hold, ex_mem_hold and mem_wb_flush all =1. Next state MEM_WAIT; counter=1.
  - else ex_br_taken: if_id_flush=1 and id_ex_flush=1; pc_pause=0 so the PC takes the branch target. This suppresses any simultaneous lu.
  - else lu: pc_pause=1, if_id_pause=1, id_ex_flush=1. Exactly one bubble; the next cycle the load is in MEM and lu clears naturally.
  - else: all outputs 0.
- MEM_WAIT:
  - Same freeze outputs as ms, held every cycle the state is entered.
  - If mem_ready=1: outputs revert to RUN rules evaluated this cycle, except that ms is ignored. Next state RUN; counter=0.
  - Else if counter==MEM_TIMEOUT: next state ABORT.
  - Else: counter+1.
  - ex_br_taken and lu are ignored while frozen.
- ABORT, one cycle:
  - mem_err=1, mem_wb_flush=1, ex_mem_hold=0. The faulting access is dropped and the pipeline drains.
  - Next state RUN.
- mem_req deasserting while in MEM_WAIT is treated as ready.
- Register index 0 never causes a hazard.
- The counter saturates; it never wraps.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three 32-bit output ports, all reset to 0 and wrapping at 2^32:
  - perf_lu_cnt: cycles with a load-use bubble.
  - perf_br_cnt: taken-branch flushes.
  - perf_mem_cnt: cycles in MEM_WAIT.
- When undefined, the ports and the counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state encodings RUN/MEM_WAIT/ABORT.
  - WDSEL_LOAD=2'b01.
  - The NPCOp encodings shared with the branch logic.
- Natural sub-module: hazard_detect. It is combinational, computes lu from the ID/EX fields, and is reused by the forwarding unit.

Test Plan:
- ex load to x5 (WDsel=01, RegWrite=1, rd=5), id_rs1=5 with use_rs1=1 → for one cycle pc_pause=if_id_pause=id_ex_flush=1; the next cycle (ex_rd now a non-load) all outputs are 0.
- Same as above but ex_rd=0, or use_rs1=0 → no stall.
- ex_br_taken=1 together with a load-use match → if_id_flush=id_ex_flush=1, pc_pause=0, no stall.
- mem_req=1 with mem_ready low for 3 cycles, then high → freeze outputs for 3 cycles, state_o=1, then RUN with no mem_err.
- mem_req=1 with mem_ready never asserted, MEM_TIMEOUT=4 → ABORT entered after the counter reaches 4; mem_err pulses for exactly one cycle; then RUN.
- rst asserted mid-MEM_WAIT → next cycle state_o=0, outputs 0, counter cleared; perf counters (when the macro is defined) read 0.
